// File: rtl/mem_arbiter_ctrl_pkg.sv
// mem_arbiter_ctrl_pkg: shared constants for the arbitrated byte-serial memory controller
package mem_arbiter_ctrl_pkg;
   localparam logic [31:0] IO_LIM_DEF = 32'h30000;
   localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_STALL = 2'd3;
   localparam int LEN_BYTE = 0, LEN_HALF = 1, LEN_WORD = 3;
   function automatic int len_w(int bytes);
      return bytes > 1 ? $clog2(bytes) : 1;
   endfunction
endpackage

// File: rtl/mem_arbiter_ctrl_rr_arbiter.sv
// mem_arbiter_ctrl_rr_arbiter: round-robin or fixed-priority pick among eligible ports
module mem_arbiter_ctrl_rr_arbiter #(
   parameter int N = 2,
   parameter int MODE = 0,
   localparam int IW = N > 1 ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          grant_en,
   input  logic [N-1:0]  eligible,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          hit
);
   logic [IW-1:0] ptr;
   int k;
   always_comb begin
      grant = '0;
      index = '0;
      hit = 1'b0;
      k = 0;
      for (int i = 0; i < N; i++) begin
         k = MODE != 0 ? i : (int'(ptr) + i) % N;
         if (!hit && eligible[k]) begin
            hit = 1'b1;
            index = k[IW-1:0];
         end
      end
      if (hit) grant[index] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr <= '0;
      else if (grant_en && hit) ptr <= index == IW'(N - 1) ? '0 : index + 1'b1;
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: multi-port arbiter driving a byte-serial RAM/IO bus, little-endian
module mem_arbiter_ctrl
   import mem_arbiter_ctrl_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_BYTES = 4,
   parameter int ARB_MODE = 0,
   parameter logic [ADDR_W-1:0] IO_LIM = ADDR_W'(IO_LIM_DEF),
   localparam int LEN_W = len_w(DATA_BYTES),
   localparam int DW = 8 * DATA_BYTES
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ready,
   input  logic                        clear,
   input  logic                        io_buffer_full,
   input  logic [7:0]                  mem_din,
   output logic [7:0]                  mem_dout,
   output logic [ADDR_W-1:0]           mem_a,
   output logic                        mem_wr,
   input  logic [NUM_PORTS-1:0]        req_valid,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
   input  logic [NUM_PORTS*DW-1:0]     req_wdata,
   output logic [NUM_PORTS-1:0]        resp_done,
   output logic [DW-1:0]               resp_rdata
);
   localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
   logic [1:0] state;
   logic [NUM_PORTS-1:0] eligible, grant, owner;
   logic [IW-1:0] gi;
   logic hit, grant_en;
   logic [ADDR_W-1:0] addr, nxt_a, sel_addr;
   logic [LEN_W-1:0] len, cnt, nxt_c;
   logic [DW-1:0] wdata, rbuf, rnext, sel_wdata;
   logic [7:0] wbyte;
   // IO-space writes are skipped while the IO buffer is full so other ports can proceed
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_elig
      assign eligible[p] = req_valid[p] &&
         !(req_write[p] && io_buffer_full && req_addr[p*ADDR_W +: ADDR_W] >= IO_LIM);
   end
   assign grant_en = ready && !clear && state == S_IDLE;
   mem_arbiter_ctrl_rr_arbiter #(.N(NUM_PORTS), .MODE(ARB_MODE)) u_arb (
      .clk(clk), .reset(reset), .grant_en(grant_en), .eligible(eligible),
      .grant(grant), .index(gi), .hit(hit)
   );
   always_comb begin
      sel_addr = req_addr[gi*ADDR_W +: ADDR_W];
      sel_wdata = req_wdata[gi*DW +: DW];
      nxt_c = cnt + 1'b1;
      nxt_a = addr + ADDR_W'(nxt_c);
      wbyte = wdata[{nxt_c, 3'b000} +: 8];
      rnext = rbuf;
      rnext[{cnt, 3'b000} +: 8] = mem_din;
   end
   // a write in flight ignores clear so the bus never sees a partial store
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         mem_a <= '0;
         mem_wr <= 1'b0;
         mem_dout <= '0;
         resp_done <= '0;
         resp_rdata <= '0;
         owner <= '0;
         addr <= '0;
         len <= '0;
         cnt <= '0;
         wdata <= '0;
         rbuf <= '0;
      end else if (clear && state != S_WRITE) begin
         state <= S_IDLE;
         mem_a <= '0;
         mem_wr <= 1'b0;
         mem_dout <= '0;
         resp_done <= '0;
         resp_rdata <= '0;
      end else if (ready) begin
         case (state)
            S_IDLE: begin
               mem_a <= hit ? sel_addr : '0;
               mem_wr <= hit && req_write[gi];
               if (hit) begin
                  state <= req_write[gi] ? S_WRITE : S_READ;
                  owner <= grant;
                  addr <= sel_addr;
                  len <= req_len[gi*LEN_W +: LEN_W];
                  wdata <= sel_wdata;
                  cnt <= '0;
                  rbuf <= '0;
                  if (req_write[gi]) mem_dout <= sel_wdata[7:0];
               end
            end
            S_READ: begin
               rbuf <= rnext;
               cnt <= nxt_c;
               mem_a <= cnt < len ? nxt_a : '0;
               if (cnt == len) begin
                  resp_done <= owner;
                  resp_rdata <= rnext;
                  state <= S_STALL;
               end
            end
            S_WRITE: begin
               if (cnt == len) begin
                  mem_a <= '0;
                  mem_wr <= 1'b0;
                  resp_done <= owner;
                  state <= S_STALL;
               end else if (io_buffer_full && nxt_a >= IO_LIM) begin
                  mem_a <= '0;
                  mem_wr <= 1'b0;
               end else begin
                  mem_dout <= wbyte;
                  mem_a <= nxt_a;
                  mem_wr <= 1'b1;
                  cnt <= nxt_c;
               end
            end
            default: begin
               resp_done <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: scoreboard bench for mem_arbiter_ctrl (round-robin plus a fixed-priority twin)
module tb_mem_arbiter_ctrl;
   typedef struct packed {
      logic [1:0]  done;
      logic [31:0] rdata;
      logic        rd;
   } exp_t;
   logic clk = 1'b0, reset = 1'b0, ready = 1'b1, clear = 1'b0, io_buffer_full = 1'b0;
   logic [7:0] mem_din, mem_dout, fp_din, fp_dout;
   logic [31:0] mem_a, fp_a, resp_rdata, fp_rdata;
   logic mem_wr, fp_wr;
   logic [1:0] req_valid = '0, req_write = '0, resp_done, fp_done;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic [3:0] req_len = '0;
   exp_t exp_q[$];
   logic [39:0] wq[$], ewq[$];
   int n_cmp = 0, n_err = 0, fp_n = 0;
   bit hold = 0, fp_on = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rd(logic [31:0] a);
      return (a >= 32'h100 && a <= 32'h103) ? (a[7:0] + 8'd1) * 8'h11 : a[7:0] ^ 8'h5A;
   endfunction
   assign mem_din = rd(mem_a);
   assign fp_din = rd(fp_a);

   mem_arbiter_ctrl dut (
      .clk(clk), .reset(reset), .ready(ready), .clear(clear), .io_buffer_full(io_buffer_full),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
      .req_wdata(req_wdata), .resp_done(resp_done), .resp_rdata(resp_rdata)
   );
   mem_arbiter_ctrl #(.ARB_MODE(1)) dut_fp (
      .clk(clk), .reset(reset), .ready(ready), .clear(clear), .io_buffer_full(io_buffer_full),
      .mem_din(fp_din), .mem_dout(fp_dout), .mem_a(fp_a), .mem_wr(fp_wr),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
      .req_wdata(req_wdata), .resp_done(fp_done), .resp_rdata(fp_rdata)
   );

   // bus write log: what was on the bus during each completed cycle
   always @(posedge clk) if (reset && ready && mem_wr) wq.push_back({mem_a, mem_dout});

   task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic set_req(int p, logic wr, logic [31:0] a, logic [1:0] l, logic [31:0] d);
      req_write[p] = wr;
      req_addr[p*32 +: 32] = a;
      req_len[p*2 +: 2] = l;
      req_wdata[p*32 +: 32] = d;
      req_valid[p] = 1'b1;
   endtask

   task automatic expect_resp(logic [1:0] d, logic [31:0] r, logic is_rd);
      exp_t e;
      e.done = d;
      e.rdata = r;
      e.rd = is_rd;
      exp_q.push_back(e);
   endtask

   task automatic collect();
      exp_t e;
      logic [39:0] w;
      if (resp_done != 2'b00) begin
         if (exp_q.size() == 0) chk("spurious_done", {62'd0, resp_done}, 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("done", {62'd0, resp_done}, {62'd0, e.done});
            if (e.rd) chk("rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
         end
         if (!hold) req_valid = req_valid & ~resp_done;
      end
      if (fp_on && fp_done != 2'b00) begin
         chk("fp_grant", {62'd0, fp_done}, 64'd1);
         fp_n++;
      end
      while (wq.size() != 0) begin
         w = wq.pop_front();
         if (ewq.size() == 0) chk("spurious_wr", {24'd0, w}, 64'd0);
         else chk("wr", {24'd0, w}, {24'd0, ewq.pop_front()});
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(negedge clk);
         collect();
      end
   endtask

   task automatic wait_resp(int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         step(1);
         c++;
      end
      if (exp_q.size() != 0) chk("timeout", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_a", {32'd0, mem_a}, 64'd0);
      chk("rst_wr", {63'd0, mem_wr}, 64'd0);
      chk("rst_dout", {56'd0, mem_dout}, 64'd0);
      chk("rst_done", {62'd0, resp_done}, 64'd0);
      chk("rst_rdata", {32'd0, resp_rdata}, 64'd0);
      reset = 1'b1;
      step(2);
      // single 4-byte read on port 1
      set_req(1, 1'b0, 32'h100, 2'd3, 32'h0);
      expect_resp(2'b10, 32'h44332211, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rd_a", {32'd0, mem_a}, k == 4 ? 64'd0 : 64'h100 + 64'(k));
         chk("rd_lat", {62'd0, resp_done}, k == 4 ? 64'd2 : 64'd0);
         collect();
      end
      step(1);
      chk("stall_done", {62'd0, resp_done}, 64'd0);
      chk("stall_a", {32'd0, mem_a}, 64'd0);
      // word write with clear raised after byte 1
      set_req(0, 1'b1, 32'h200, 2'd3, 32'hDEADBEEF);
      ewq.push_back({32'h200, 8'hEF});
      ewq.push_back({32'h201, 8'hBE});
      ewq.push_back({32'h202, 8'hAD});
      ewq.push_back({32'h203, 8'hDE});
      expect_resp(2'b01, 32'h0, 1'b0);
      step(2);
      clear = 1'b1;
      step(2);
      clear = 1'b0;
      wait_resp(10);
      step(2);
      // IO byte write held off by a full IO buffer
      io_buffer_full = 1'b1;
      set_req(0, 1'b1, 32'h30000, 2'd0, 32'h000000AB);
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("io_hold_wr", {63'd0, mem_wr}, 64'd0);
         chk("io_hold_a", {32'd0, mem_a}, 64'd0);
      end
      io_buffer_full = 1'b0;
      ewq.push_back({32'h30000, 8'hAB});
      expect_resp(2'b01, 32'h0, 1'b0);
      step(1);
      chk("io_wr", {63'd0, mem_wr}, 64'd1);
      chk("io_a", {32'd0, mem_a}, 64'h30000);
      chk("io_dout", {56'd0, mem_dout}, 64'hAB);
      wait_resp(5);
      step(2);
      // 2-byte write crossing into IO space, throttled for two cycles mid-access
      io_buffer_full = 1'b1;
      set_req(1, 1'b1, 32'h2FFFF, 2'd1, 32'h00003412);
      ewq.push_back({32'h2FFFF, 8'h12});
      ewq.push_back({32'h30000, 8'h34});
      expect_resp(2'b10, 32'h0, 1'b0);
      step(1);
      chk("thr_first_wr", {63'd0, mem_wr}, 64'd1);
      step(1);
      chk("thr_stall_wr", {63'd0, mem_wr}, 64'd0);
      step(1);
      io_buffer_full = 1'b0;
      step(1);
      chk("thr_lat_early", exp_q.size(), 1);
      step(1);
      chk("thr_lat", exp_q.size(), 0);
      step(2);
      // clear aborts a read; the other pending port follows
      set_req(0, 1'b0, 32'h100, 2'd3, 32'h0);
      step(1);
      set_req(1, 1'b0, 32'h104, 2'd0, 32'h0);
      expect_resp(2'b10, {24'd0, rd(32'h104)}, 1'b1);
      step(1);
      clear = 1'b1;
      step(1);
      chk("clr_rd_a", {32'd0, mem_a}, 64'd0);
      chk("clr_rd_done", {62'd0, resp_done}, 64'd0);
      clear = 1'b0;
      req_valid[0] = 1'b0;
      step(1);
      chk("clr_next_a", {32'd0, mem_a}, 64'h104);
      chk("clr_next_wr", {63'd0, mem_wr}, 64'd0);
      wait_resp(5);
      step(2);
      // asynchronous reset in the middle of a write
      set_req(0, 1'b1, 32'h300, 2'd3, 32'h01020304);
      step(1);
      chk("ar_pre_wr", {63'd0, mem_wr}, 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_wr", {63'd0, mem_wr}, 64'd0);
      chk("ar_a", {32'd0, mem_a}, 64'd0);
      chk("ar_done", {62'd0, resp_done}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0;
      step(1);
      // continuous requests on both ports: RR alternates from port 0, fixed priority sticks to 0
      hold = 1;
      fp_on = 1;
      set_req(0, 1'b0, 32'h10, 2'd0, 32'h0);
      set_req(1, 1'b0, 32'h20, 2'd0, 32'h0);
      for (int k = 0; k < 4; k++)
         expect_resp(k % 2 == 0 ? 2'b01 : 2'b10, {24'd0, rd(k % 2 == 0 ? 32'h10 : 32'h20)}, 1'b1);
      wait_resp(40);
      req_valid = '0;
      hold = 0;
      fp_on = 0;
      chk("fp_count", {63'd0, fp_n >= 3}, 64'd1);
      step(4);
      chk("wr_left", ewq.size(), 0);
      chk("exp_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
